// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RISC-V IF stage: PC, four-byte instruction fetch, IF/ID hand-off.
// Optional direct-mapped I-cache compiled in with `define ICACHE_EN.
module if_fetch #(
   parameter logic [31:0] START_PC     = 32'h0000_0000,
   parameter int          ICACHE_LINES = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [7:0]  mem_rdata,
   output logic        if_flag,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stall_req
);

   typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3, S_DONE} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [23:0] r_buf;
   logic        w_unused_stall;

   assign w_unused_stall = ^stall[5:2];

`ifdef ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [ICACHE_LINES-1:0] r_cvalid;
   logic [TAG_W-1:0]        r_ctag  [ICACHE_LINES];
   logic [31:0]             r_cdata [ICACHE_LINES];
   logic [IDX_W-1:0]        w_idx;
   logic [TAG_W-1:0]        w_tag;
   logic                    w_hit;
   logic                    w_fill;

   assign w_idx  = r_pc[IDX_W+1:2];
   assign w_tag  = r_pc[31:IDX_W+2];
   assign w_hit  = r_cvalid[w_idx] && (r_ctag[w_idx] == w_tag);
   assign w_fill = !rst && !branch_flag && (r_state == S_B3) && mem_valid;

   always_ff @(posedge clk) begin
      if (rst)
         r_cvalid <= '0;
      else if (w_fill)
         r_cvalid[w_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_ctag[w_idx]  <= w_tag;
         r_cdata[w_idx] <= {mem_rdata, r_buf};
      end
   end
`else
   localparam int unused_icache_lines = ICACHE_LINES;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= START_PC;
         r_buf     <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         if_flag   <= 1'b0;
         if_pc     <= '0;
         if_inst   <= '0;
         stall_req <= 1'b0;
      end else if (branch_flag) begin
         // Redirect wins over everything: partial buffer, pending byte and transfer are dropped.
         r_state   <= S_IDLE;
         r_pc      <= branch_target;
         mem_req   <= 1'b0;
         if_flag   <= 1'b0;
         stall_req <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!stall[0]) begin
`ifdef ICACHE_EN
                  if (w_hit) begin
                     r_state <= S_DONE;
                     if_flag <= 1'b1;
                     if_inst <= r_cdata[w_idx];
                     if_pc   <= r_pc + 32'd4;
                  end else
`endif
                  begin
                     r_state   <= S_B0;
                     mem_req   <= 1'b1;
                     mem_addr  <= r_pc;
                     stall_req <= 1'b1;
                  end
               end
            end
            S_B0: begin
               if (mem_valid) begin
                  r_buf[7:0] <= mem_rdata;
                  r_state    <= S_B1;
                  mem_addr   <= r_pc + 32'd1;
               end
            end
            S_B1: begin
               if (mem_valid) begin
                  r_buf[15:8] <= mem_rdata;
                  r_state     <= S_B2;
                  mem_addr    <= r_pc + 32'd2;
               end
            end
            S_B2: begin
               if (mem_valid) begin
                  r_buf[23:16] <= mem_rdata;
                  r_state      <= S_B3;
                  mem_addr     <= r_pc + 32'd3;
               end
            end
            S_B3: begin
               if (mem_valid) begin
                  r_state   <= S_DONE;
                  mem_req   <= 1'b0;
                  stall_req <= 1'b0;
                  if_flag   <= 1'b1;
                  if_inst   <= {mem_rdata, r_buf};
                  if_pc     <= r_pc + 32'd4;
               end
            end
            S_DONE: begin
               // Outputs hold while IF/ID is stopped; otherwise hand off and move on.
               if (!stall[1]) begin
                  if_flag <= 1'b0;
                  r_pc    <= r_pc + 32'd4;
                  if (stall[0]) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state   <= S_B0;
                     mem_req   <= 1'b1;
                     mem_addr  <= r_pc + 32'd4;
                     stall_req <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - Scoreboard bench for if_fetch with a random-latency byte memory.
module tb_if_fetch;

   localparam logic [31:0] START_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = '0;
   logic        mem_valid = 1'b0;
   logic [7:0]  mem_rdata = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        if_flag;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stall_req;

   if_fetch #(.START_PC(START_PC), .ICACHE_LINES(128)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_flag(branch_flag), .branch_target(branch_target),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .if_flag(if_flag), .if_pc(if_pc), .if_inst(if_inst),
      .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gen_pc;
   int          byte_k = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_xfer = 0;
   int          pct = 100;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] boot;
      logic [7:0]  h;
      boot = 32'h0010_0513;
      if (a < 32'd4) return boot[{a[1:0], 3'b000} +: 8];
      h = a[7:0] * 8'd37;
      return h ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   // Expected transfers are the word stream from the last restart point onward.
   task automatic fill();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.pc   = gen_pc;
         e.pc4  = gen_pc + 32'd4;
         e.inst = word_at(gen_pc);
         exp_q.push_back(e);
         gen_pc = gen_pc + 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] t);
      exp_q.delete();
      gen_pc = t;
      byte_k = 0;
      fill();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      fill();
   endtask

   // Byte memory: answers in the request cycle with a random wait-state probability.
   always begin
      @(posedge clk);
      #1;
      if (mem_req && ($urandom_range(0, 99) < pct)) begin
         mem_valid = 1'b1;
         mem_rdata = mem_byte(mem_addr);
      end else begin
         mem_valid = 1'b0;
         mem_rdata = 8'($urandom);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && !branch_flag) begin
         if (mem_req && mem_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL byte_addr: got %h expected none", mem_addr);
            end else begin
               chk("byte_addr", mem_addr, exp_q[0].pc + 32'(byte_k));
            end
            byte_k++;
         end
         if (if_flag && !stall[1]) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL xfer_empty: got %h expected none", if_inst);
            end else begin
               e = exp_q.pop_front();
               chk("xfer_pc", if_pc, e.pc4);
               chk("xfer_inst", if_inst, e.inst);
            end
            byte_k = 0;
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      logic [31:0] inst1;
      int          r;
      int          nreq;
      bit          got;
      restart(START_PC);
      rst = 1'b1;
      tick();
      tick();
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_flag", 32'(if_flag), 0);
      chk("rst_pc", if_pc, 0);
      chk("rst_inst", if_inst, 0);
      chk("rst_sreq", 32'(stall_req), 0);
      rst = 1'b0;

      for (int k = 0; k < 4; k++) begin
         tick();
         chk("b_req", 32'(mem_req), 1);
         chk("b_addr", mem_addr, 32'(k));
         chk("b_sreq", 32'(stall_req), 1);
      end
      tick();
      chk("first_flag", 32'(if_flag), 1);
      chk("first_inst", if_inst, 32'h0010_0513);
      chk("first_pc", if_pc, 32'd4);
      chk("done_sreq", 32'(stall_req), 0);

      stall = 6'b000010;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_flag", 32'(if_flag), 1);
         chk("hold_inst", if_inst, 32'h0010_0513);
         chk("hold_pc", if_pc, 32'd4);
         chk("hold_req", 32'(mem_req), 0);
      end
      stall = '0;
      tick();
      chk("resume_addr", mem_addr, 32'd4);
      chk("resume_req", 32'(mem_req), 1);

      tick();
      tick();
      chk("b2_addr", mem_addr, 32'd6);
      branch_flag = 1'b1;
      branch_target = 32'h100;
      restart(32'h100);
      tick();
      branch_flag = 1'b0;
      chk("br_req_low", 32'(mem_req), 0);
      chk("br_flag_low", 32'(if_flag), 0);
      tick();
      chk("br_req", 32'(mem_req), 1);
      chk("br_addr", mem_addr, 32'h100);
      for (int k = 0; k < 4; k++) tick();
      chk("br_inst", if_inst, word_at(32'h100));
      chk("br_pc", if_pc, 32'h104);

      branch_flag = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      restart(32'hFFFF_FFFC);
      tick();
      branch_flag = 1'b0;
      tick();
      chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
      for (int k = 0; k < 4; k++) tick();
      chk("wrap_pc", if_pc, 32'h0);
      chk("wrap_inst", if_inst, word_at(32'hFFFF_FFFC));
      tick();
      chk("wrap_next", mem_addr, 32'h0);

      tick();
      chk("b1_addr", mem_addr, 32'd1);
      rst = 1'b1;
      restart(START_PC);
      tick();
      chk("mid_req", 32'(mem_req), 0);
      chk("mid_addr", mem_addr, 0);
      chk("mid_flag", 32'(if_flag), 0);
      chk("mid_sreq", 32'(stall_req), 0);
      rst = 1'b0;
      tick();
      chk("mid_restart", mem_addr, START_PC);

`ifdef ICACHE_EN
      branch_flag = 1'b1;
      branch_target = 32'h40;
      restart(32'h40);
      tick();
      branch_flag = 1'b0;
      nreq = 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         if (mem_req) nreq++;
         got = if_flag;
      end
      chk("c1_done", 32'(got), 1);
      chk("c1_req", 32'(nreq > 0), 1);
      inst1 = if_inst;
      branch_flag = 1'b1;
      restart(32'h40);
      tick();
      branch_flag = 1'b0;
      chk("c2_idle_req", 32'(mem_req), 0);
      tick();
      chk("c2_flag", 32'(if_flag), 1);
      chk("c2_req", 32'(mem_req), 0);
      chk("c2_inst", if_inst, inst1);
      chk("c2_model", if_inst, word_at(32'h40));
`endif

      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) pct = $urandom_range(30, 100);
         rst = 1'b0;
         branch_flag = 1'b0;
         stall = {4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0)};
         r = $urandom_range(0, 199);
         if (r == 0) begin
            rst = 1'b1;
            restart(START_PC);
         end else if (r < 7) begin
            if (r == 1) tgt = $urandom;
            else if (r == 2) tgt = 32'hFFFF_FFF4;
            else tgt = 32'($urandom_range(0, 31)) << 2;
            branch_flag = 1'b1;
            branch_target = tgt;
            restart(tgt);
         end
         tick();
      end
      rst = 1'b0;
      branch_flag = 1'b0;
      stall = '0;
      chk("xfer_seen", 32'(n_xfer > 50), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
